// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, direction constants, counter sizing.
// Used by the APB requester and by slave-side models that decode the same states.
// No logic; types, constants and one elaboration-time helper only.
package apb_pkg;

   typedef logic [1:0] apb_state_t;

   localparam apb_state_t ST_IDLE   = 2'd0;
   localparam apb_state_t ST_SETUP  = 2'd1;
   localparam apb_state_t ST_ACCESS = 2'd2;
   localparam apb_state_t ST_RESP   = 2'd3;

   localparam logic APB_READ  = 1'b0;
   localparam logic APB_WRITE = 1'b1;

   // Wait-counter width: clog2(TIMEOUT+1), never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned t);
      return (t == 0) ? 1 : $clog2(t + 1);
   endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating ACCESS-phase wait counter with an expiry flag at TIMEOUT-1.
// Latency: expired_o is decoded from the registered count (same cycle as the count).
// No backpressure; clr_i wins over en_i, expired_o is constant 0 when TIMEOUT=0.
module apb_timeout_cnt
   import apb_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
)(
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned     CW      = cnt_width(TIMEOUT);
   localparam logic [CW-1:0]   CNT_MAX = '1;
   localparam logic [CW-1:0]   LAST    = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam bit              TO_EN   = (TIMEOUT != 0);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: clear on request, otherwise count up and stick at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign expired_o = TO_EN && (cnt_q == LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester: one command at a time turned into SETUP/ACCESS, response pulsed back.
// Latency: accept->rsp_valid is 3 edges for a zero-wait slave, +1 per wait state.
// Backpressure: cmd_ready only in IDLE; slave stalls via pready, optional timeout abort.
module apb_master
   import apb_pkg::*;
#(
   parameter int unsigned AW      = 12,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 16
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_wdata,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   output logic          psel,
   output logic          penable,
   output logic          pwrite,
   output logic [AW-1:0] paddr,
   output logic [DW-1:0] pwdata,
   input  logic [DW-1:0] prdata,
   input  logic          pready,
   input  logic          pslverr
);

   apb_state_t    state_q, state_d;
   logic          psel_q, psel_d;
   logic          penable_q, penable_d;
   logic          pwrite_q, pwrite_d;
   logic [AW-1:0] paddr_q, paddr_d;
   logic [DW-1:0] pwdata_q, pwdata_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
   logic          rsp_err_q, rsp_err_d;
   logic          to_expired;

   // Counter restarts while in SETUP so it reads 0 in the first ACCESS cycle.
   apb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_to_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (state_q == ST_SETUP),
      .en_i      ((state_q == ST_ACCESS) && !pready),
      .expired_o (to_expired)
   );

   // State and registered-output flops; reset drops any transfer in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Next state: pready only matters in ACCESS; timeout aborts a stalled ACCESS.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (cmd_valid) state_d = ST_SETUP;
         ST_SETUP:  state_d = ST_ACCESS;
         ST_ACCESS: if (pready || to_expired) state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs; address/data hold outside a transfer.
   always_comb begin
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               psel_d    = 1'b1;
               penable_d = 1'b0;
               pwrite_d  = cmd_write;
               paddr_d   = cmd_addr;
               pwdata_d  = cmd_wdata;
            end
         end
         ST_SETUP: begin
            penable_d = 1'b1;
         end
         ST_ACCESS: begin
            if (pready) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = (pwrite_q == APB_WRITE) ? '0 : prdata;
               rsp_err_d   = pslverr;
            end else if (to_expired) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
            end
         end
         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase
   end

   assign cmd_ready = rst_n && (state_q == ST_IDLE);
   assign psel      = psel_q;
   assign penable   = penable_q;
   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: write/read/wait/error/timeout/back-to-back/reset.
// A second instance with TIMEOUT=0 checks that a stalled ACCESS never aborts.
// Inputs driven at negedge, outputs sampled at negedge.
module tb_apb_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_valid0;
   logic        cmd_write;
   logic [11:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [31:0] prdata;
   logic        pready, pslverr;

   logic        cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite;
   logic [31:0] rsp_rdata, pwdata;
   logic [11:0] paddr;

   logic        cmd_ready0, rsp_valid0, rsp_err0, psel0, penable0, pwrite0;
   logic [31:0] rsp_rdata0, pwdata0;
   logic [11:0] paddr0;

   int checks = 0;
   int errors = 0;

   // observations collected by do_xfer
   int          psel_cnt, pen_cnt, rsp_cnt, rsp_cyc;
   bit          stable, acc_ok, end_rdy, timed_out;
   logic [31:0] rsp_dat;
   logic        rsp_e;

   always #5 clk = ~clk;

   apb_master #(.AW(12), .DW(32), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   apb_master #(.AW(12), .DW(32), .TIMEOUT(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
      .psel(psel0), .penable(penable0), .pwrite(pwrite0), .paddr(paddr0), .pwdata(pwdata0),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   // Runs one transfer on dut with a slave that raises pready after nwait ACCESS
   // wait cycles; records what was seen. Cycle c=1 is the cycle after the accept edge.
   task automatic do_xfer(input logic w, input logic [11:0] a, input logic [31:0] d,
                          input int nwait, input logic [31:0] rd, input logic se,
                          input int budget);
      int c;
      bit done;
      psel_cnt = 0; pen_cnt = 0; rsp_cnt = 0; rsp_cyc = -1;
      stable = 1'b1; end_rdy = 1'b0; timed_out = 1'b0; rsp_dat = '0; rsp_e = 1'b0;
      @(negedge clk);
      cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
      pready = 1'b0; pslverr = 1'b0; prdata = rd;
      acc_ok = cmd_ready;
      c = 0; done = 1'b0;
      while (!done) begin
         @(negedge clk);
         c++;
         if (c == 1) cmd_valid = 1'b0;
         if (psel) begin
            psel_cnt++;
            if (paddr !== a || pwdata !== d || pwrite !== w) stable = 1'b0;
         end
         if (penable) pen_cnt++;
         if (rsp_valid) begin
            rsp_cnt++;
            if (rsp_cyc < 0) begin rsp_cyc = c; rsp_dat = rsp_rdata; rsp_e = rsp_err; end
         end
         if (penable && pen_cnt == nwait + 1) begin pready = 1'b1; pslverr = se; end
         else begin pready = 1'b0; pslverr = 1'b0; end
         if (rsp_cyc >= 0 && c == rsp_cyc + 1) begin end_rdy = cmd_ready; done = 1'b1; end
         if (c >= budget) begin timed_out = 1'b1; done = 1'b1; end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_valid = 0; cmd_valid0 = 0; cmd_write = 0; cmd_addr = 0;
      cmd_wdata = 0; prdata = 0; pready = 0; pslverr = 0;
      #2;
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_rdy_low got %b exp 0", cmd_ready); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b exp 1", cmd_ready); end
      checks++;
      if ({psel, penable, pwrite, rsp_valid, rsp_err} !== 5'b0 || paddr !== 12'h0 ||
          pwdata !== 32'h0 || rsp_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_outs got psel=%b pen=%b pw=%b rv=%b re=%b pa=%h pd=%h rd=%h exp all 0",
                  psel, penable, pwrite, rsp_valid, rsp_err, paddr, pwdata, rsp_rdata);
      end
   endtask

   task automatic test_write();
      do_xfer(1'b1, 12'h010, 32'hA5A5_0001, 1, 32'hFFFF_FFFF, 1'b0, 30);
      checks++; if (timed_out) begin errors++; $display("FAIL wr_done got timeout exp response"); end
      checks++; if (acc_ok !== 1'b1) begin errors++; $display("FAIL wr_accept got %b exp 1", acc_ok); end
      checks++; if (psel_cnt != 3) begin errors++; $display("FAIL wr_psel_cycles got %0d exp 3", psel_cnt); end
      checks++; if (pen_cnt != 2) begin errors++; $display("FAIL wr_pen_cycles got %0d exp 2", pen_cnt); end
      checks++; if (stable !== 1'b1) begin errors++; $display("FAIL wr_stable got %b exp 1", stable); end
      checks++; if (rsp_cyc != 4) begin errors++; $display("FAIL wr_rsp_cycle got %0d exp 4", rsp_cyc); end
      checks++; if (rsp_cnt != 1) begin errors++; $display("FAIL wr_rsp_pulse got %0d exp 1", rsp_cnt); end
      checks++; if (rsp_e !== 1'b0 || rsp_dat !== 32'h0) begin errors++; $display("FAIL wr_rsp got err=%b data=%h exp 0/0", rsp_e, rsp_dat); end
      checks++; if (end_rdy !== 1'b1) begin errors++; $display("FAIL wr_idle_rdy got %b exp 1", end_rdy); end
      checks++; if (paddr !== 12'h010 || pwdata !== 32'hA5A5_0001) begin errors++; $display("FAIL wr_hold got %h/%h exp 010/a5a50001", paddr, pwdata); end
   endtask

   task automatic test_read_zero_wait();
      do_xfer(1'b0, 12'h004, 32'h0, 0, 32'h0000_1234, 1'b0, 30);
      checks++; if (timed_out) begin errors++; $display("FAIL rd0_done got timeout exp response"); end
      checks++; if (pen_cnt != 1) begin errors++; $display("FAIL rd0_pen_cycles got %0d exp 1", pen_cnt); end
      checks++; if (rsp_cyc != 3) begin errors++; $display("FAIL rd0_rsp_cycle got %0d exp 3", rsp_cyc); end
      checks++; if (rsp_dat !== 32'h0000_1234 || rsp_e !== 1'b0) begin errors++; $display("FAIL rd0_rsp got data=%h err=%b exp 00001234/0", rsp_dat, rsp_e); end
      checks++; if (stable !== 1'b1) begin errors++; $display("FAIL rd0_stable got %b exp 1", stable); end
   endtask

   task automatic test_read_wait_err();
      do_xfer(1'b0, 12'h0FC, 32'h0, 3, 32'hDEAD_BEEF, 1'b1, 30);
      checks++; if (timed_out) begin errors++; $display("FAIL rdw_done got timeout exp response"); end
      checks++; if (pen_cnt != 4) begin errors++; $display("FAIL rdw_pen_cycles got %0d exp 4", pen_cnt); end
      checks++; if (rsp_cyc != 6) begin errors++; $display("FAIL rdw_rsp_cycle got %0d exp 6", rsp_cyc); end
      checks++; if (rsp_dat !== 32'hDEAD_BEEF || rsp_e !== 1'b1) begin errors++; $display("FAIL rdw_rsp got data=%h err=%b exp deadbeef/1", rsp_dat, rsp_e); end
   endtask

   task automatic test_timeout();
      do_xfer(1'b0, 12'h020, 32'h0, 1000, 32'h5555_AAAA, 1'b0, 40);
      checks++; if (timed_out) begin errors++; $display("FAIL to_done got no response exp abort"); end
      checks++; if (pen_cnt != 16) begin errors++; $display("FAIL to_access_cycles got %0d exp 16", pen_cnt); end
      checks++; if (psel_cnt != 17) begin errors++; $display("FAIL to_psel_cycles got %0d exp 17", psel_cnt); end
      checks++; if (rsp_cyc != 18) begin errors++; $display("FAIL to_rsp_cycle got %0d exp 18", rsp_cyc); end
      checks++; if (rsp_e !== 1'b1 || rsp_dat !== 32'h0) begin errors++; $display("FAIL to_rsp got err=%b data=%h exp 1/0", rsp_e, rsp_dat); end
   endtask

   task automatic test_timeout_disabled();
      int rv0;
      rv0 = 0;
      @(negedge clk);
      cmd_write = 1'b0; cmd_addr = 12'h030; cmd_valid0 = 1'b1; pready = 1'b0;
      @(negedge clk);
      cmd_valid0 = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (rsp_valid0) rv0++;
      end
      checks++; if ({psel0, penable0} !== 2'b11) begin errors++; $display("FAIL to0_stuck got psel=%b pen=%b exp 1/1", psel0, penable0); end
      checks++; if (rv0 != 0) begin errors++; $display("FAIL to0_no_rsp got %0d exp 0", rv0); end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (psel0 !== 1'b0 || cmd_ready0 !== 1'b1) begin errors++; $display("FAIL to0_recover got psel=%b rdy=%b exp 0/1", psel0, cmd_ready0); end
   endtask

   task automatic test_back_to_back();
      logic [11:0] rdy_v, rsp_v, psel_v;
      int overlap;
      rdy_v = '0; rsp_v = '0; psel_v = '0; overlap = 0;
      @(negedge clk);
      cmd_write = 1'b1; cmd_addr = 12'h100; cmd_wdata = 32'h1; cmd_valid = 1'b1;
      pready = 1'b1; pslverr = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) @(negedge clk);
         rdy_v[k] = cmd_ready; rsp_v[k] = rsp_valid; psel_v[k] = psel;
         if (psel && cmd_ready) overlap++;
         if (k == 11) begin cmd_valid = 1'b0; pready = 1'b0; end
      end
      checks++; if (rdy_v !== 12'h111) begin errors++; $display("FAIL b2b_accepts got %h exp 111", rdy_v); end
      checks++; if (rsp_v !== 12'h888) begin errors++; $display("FAIL b2b_rsp got %h exp 888", rsp_v); end
      checks++; if (psel_v !== 12'h666) begin errors++; $display("FAIL b2b_psel got %h exp 666", psel_v); end
      checks++; if (overlap != 0) begin errors++; $display("FAIL b2b_overlap got %0d exp 0", overlap); end
   endtask

   task automatic test_stray_pready();
      int bad;
      bad = 0;
      @(negedge clk);
      cmd_valid = 1'b0; pready = 1'b1; pslverr = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (psel || penable || rsp_valid || !cmd_ready) bad++;
      end
      pready = 1'b0; pslverr = 1'b0;
      checks++; if (bad != 0) begin errors++; $display("FAIL stray_pready got %0d bad cycles exp 0", bad); end
   endtask

   task automatic test_reset_mid_access();
      int rv;
      rv = 0;
      @(negedge clk);
      cmd_write = 1'b0; cmd_addr = 12'h040; cmd_valid = 1'b1; pready = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      checks++; if ({psel, penable} !== 2'b11) begin errors++; $display("FAIL rst_in_access got psel=%b pen=%b exp 1/1", psel, penable); end
      #3 rst_n = 1'b0;
      #1;
      checks++; if ({psel, penable, cmd_ready, rsp_valid} !== 4'b0) begin errors++; $display("FAIL rst_async got psel=%b pen=%b rdy=%b rv=%b exp 0", psel, penable, cmd_ready, rsp_valid); end
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid) rv++;
      end
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (rsp_valid) rv++;
      end
      checks++; if (rv != 0) begin errors++; $display("FAIL rst_no_rsp got %0d exp 0", rv); end
      checks++; if (cmd_ready !== 1'b1 || paddr !== 12'h0) begin errors++; $display("FAIL rst_idle got rdy=%b paddr=%h exp 1/000", cmd_ready, paddr); end
      do_xfer(1'b1, 12'h044, 32'h0BAD_F00D, 0, 32'h0, 1'b0, 30);
      checks++; if (timed_out || rsp_cyc != 3 || rsp_e !== 1'b0) begin errors++; $display("FAIL rst_after_wr got cyc=%0d err=%b to=%b exp 3/0/0", rsp_cyc, rsp_e, timed_out); end
      checks++; if (stable !== 1'b1 || psel_cnt != 2) begin errors++; $display("FAIL rst_after_bus got stable=%b psel=%0d exp 1/2", stable, psel_cnt); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_zero_wait();
      test_read_wait_err();
      test_timeout();
      test_timeout_disabled();
      test_back_to_back();
      test_stray_pready();
      test_reset_mid_access();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_master.md
# apb_master

APB requester that converts single-transfer commands from an internal controller (register sequencer, test host) into APB SETUP/ACCESS cycles toward peripheral slaves such as the timer register block. One outstanding transfer at a time, with registered APB outputs, read-data capture, slave-error passthrough and an optional wait-state timeout. It sits between the command source and the APB fabric, the requesting end of the bus the timer slaves respond on.

## Interface

- AW, 12, address width
- DW, 32, data width
- TIMEOUT, 16, max ACCESS cycles without pready before abort; 0 disables timeout
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  AW  transfer address
- cmd_wdata  in  DW  write data (ignored for reads)
- rsp_valid  out  1  one-cycle pulse: transfer finished
- rsp_rdata  out  DW  read data, valid with rsp_valid (0 for writes and timeouts)
- rsp_err  out  1  pslverr or timeout, valid with rsp_valid
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  AW  APB address
- pwdata  out  DW  APB write data
- prdata  in  DW  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error (tie 0 for slaves without it)

## Operation

- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1, psel=0, penable=0. On cmd_valid: latch cmd_write/addr/wdata into pwrite/paddr/pwdata, go SETUP.
- SETUP (exactly 1 cycle): psel=1, penable=0, cmd_ready=0, go ACCESS.
- ACCESS: psel=1, penable=1. pready sampled only here; pready in SETUP/IDLE/RESP ignored.
  - pready=1: capture prdata (reads only; writes capture 0), rsp_err<=pslverr, go RESP, deassert psel/penable in the same edge.
  - pready=0 and TIMEOUT!=0 and wait count == TIMEOUT-1: rsp_rdata<=0, rsp_err<=1, go RESP (abort).
  - Otherwise stay; wait count +1, saturating.
- RESP (1 cycle): rsp_valid=1, psel=0, penable=0, go IDLE.
- pwrite/paddr/pwdata stable from SETUP through end of ACCESS; they hold their last values in IDLE/RESP (no return to 0).
- Wait counter: width clog2(TIMEOUT+1), cleared on entry to ACCESS.
- Reset (any state, including mid-ACCESS): async return to IDLE; transfer discarded, no rsp_valid.

## Timing

- Reset values: cmd_ready=1 after release (0 while rst_n low), psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- All APB and rsp outputs registered; cmd_ready decoded from state.
- Accept at edge E0 -> SETUP at E0..E1 -> ACCESS from E1.
- Zero-wait slave (pready high in first ACCESS cycle): rsp_valid high E2..E3; transfer period 4 cycles.
- Registered-pready slave (pready one cycle after penable): ACCESS 2 cycles, rsp_valid E3..E4; period 5 cycles.
- N wait states add N cycles. Timeout: exactly TIMEOUT ACCESS cycles then RESP.
- Back-to-back: next command accepted in the IDLE cycle after RESP; no pipelining.

## Structure

- Shared package apb_pkg: state encoding localparams (IDLE/SETUP/ACCESS/RESP), APB direction constants (APB_READ=0, APB_WRITE=1); reused by the APB slave interface testbench models.
- One sub-module: apb_timeout_cnt (clear, enable, saturating count, expired flag at TIMEOUT-1; constant 0 when TIMEOUT=0).
- FSM, address/data registers, response registers in apb_master.

## Test plan

- Write addr=0x010 data=0xA5A5_0001 against registered-pready slave -> psel 1 for 3 cycles, penable 1 for last 2, paddr/pwdata stable, rsp_valid 1 cycle at E3, rsp_err=0, rsp_rdata=0.
- Read addr=0x004, slave returns 0x0000_1234 with pready in first ACCESS -> rsp_rdata=0x1234 at E2, rsp_err=0.
- Read with 3 wait states and pslverr=1 at completion -> ACCESS 4 cycles, rsp_err=1, prdata captured.
- TIMEOUT=16, pready never asserts -> exactly 16 ACCESS cycles, psel drops, rsp_valid with rsp_err=1, rsp_rdata=0; TIMEOUT=0 -> stays in ACCESS indefinitely.
- cmd_valid held high for 3 commands -> each accepted only in IDLE, no overlap, psel low ≥1 cycle between transfers; stray pready in IDLE -> ignored.
- rst_n asserted mid-ACCESS -> psel/penable 0 immediately, no rsp_valid; after release, new write completes normally.
